fb_port_arbiter: RTL and testbench

Arbitrates the single port of the shared frame-buffer BRAM (30720 × 12-bit) between the VGA display read path and the camera capture write path. Display reads have strict priority and fixed latency. Camera writes are buffered in a small FIFO and issued only in cycles with no read. Sits between the capture pixel packer, the VGA timing controller (its ADDRESS_O/VIDEO_EN_O feed RD_ADDR_I/RD_EN_I) and the BRAM primitive.

---
 rtl/fb_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// fb_port_arbiter
// Shares the single port of the frame-buffer BRAM between the VGA display read
// path (strict priority, fixed 3-cycle latency) and the camera write path
// (buffered in a small FIFO and issued only in cycles without a read).
//
// Ports
//   CLK_25_I       25 MHz pixel clock, sole clock
//   RST_I          synchronous active-high reset
//   ENABLE_I       arbitration enable (IDLE <-> RUN, RUN -> FLUSH)
//   WR_VALID_I     camera write request
//   WR_ADDR_I      camera write address
//   WR_DATA_I      camera write pixel
//   WR_READY_O     FIFO accepts a write this cycle
//   RD_EN_I        display read request, no backpressure
//   RD_ADDR_I      display read address
//   RD_DATA_O      read pixel, valid when RD_VALID_O
//   RD_VALID_O     read data valid, 3 cycles after RD_EN_I
//   BRAM_EN_O      BRAM port enable
//   BRAM_WE_O      BRAM write enable
//   BRAM_ADDR_O    BRAM address (holds in idle slots)
//   BRAM_WDATA_O   BRAM write data (holds in idle and read slots)
//   BRAM_RDATA_I   BRAM read data, 1-cycle latency
//   FIFO_LEVEL_O   writes accepted but not yet written to BRAM
//   DROP_CNT_O     saturating count of writes offered while not ready
//   ADDR_ERR_O     sticky flag: accepted write with address >= DEPTH
// -----------------------------------------------------------------------------
module fb_port_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 12,
   parameter int DEPTH      = 30720,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              CLK_25_I,
   input  logic              RST_I,
   input  logic              ENABLE_I,
   input  logic              WR_VALID_I,
   input  logic [ADDR_W-1:0] WR_ADDR_I,
   input  logic [DATA_W-1:0] WR_DATA_I,
   output logic              WR_READY_O,
   input  logic              RD_EN_I,
   input  logic [ADDR_W-1:0] RD_ADDR_I,
   output logic [DATA_W-1:0] RD_DATA_O,
   output logic              RD_VALID_O,
   output logic              BRAM_EN_O,
   output logic              BRAM_WE_O,
   output logic [ADDR_W-1:0] BRAM_ADDR_O,
   output logic [DATA_W-1:0] BRAM_WDATA_O,
   input  logic [DATA_W-1:0] BRAM_RDATA_I,
   output logic [3:0]        FIFO_LEVEL_O,
   output logic [15:0]       DROP_CNT_O,
   output logic              ADDR_ERR_O
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [3:0]        LVL_FULL = FIFO_DEPTH[3:0];
   localparam logic [ADDR_W:0]   ADDR_LIM = DEPTH[ADDR_W:0];
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;        // entries still held in FIFO storage
   logic [3:0]        r_level;      // r_cnt plus the write currently on the port
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
   logic              r_wr_ready;
   logic [15:0]       r_drop;
   logic              r_addr_err;
   logic              r_bram_en;
   logic              r_bram_we;
   logic [ADDR_W-1:0] r_bram_addr;
   logic [DATA_W-1:0] r_bram_wdata;
   logic              r_rd_p1;      // read slot on the port this cycle
   logic              r_rd_p2;      // BRAM_RDATA_I carries read data this cycle
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   logic              w_active;
   logic              w_addr_ok;
   logic              w_push;
   logic              w_bad_addr;
   logic              w_drop;
   logic              w_rd_slot;
   logic              w_pop;
   logic [3:0]        w_cnt_nxt;
   logic [3:0]        w_level_nxt;
   logic [1:0]        w_state_nxt;
   logic              w_ready_nxt;

   assign w_active    = (r_state == ST_RUN) || (r_state == ST_FLUSH);
   assign w_addr_ok   = ({1'b0, WR_ADDR_I} < ADDR_LIM);
   assign w_push      = WR_VALID_I && r_wr_ready && w_addr_ok;
   assign w_bad_addr  = WR_VALID_I && r_wr_ready && !w_addr_ok;
   assign w_drop      = WR_VALID_I && !r_wr_ready;
   // Reads always win the port; a write only takes a slot nobody reads in.
   assign w_rd_slot   = w_active && RD_EN_I;
   assign w_pop       = w_active && !RD_EN_I && (r_cnt != 4'd0);
   assign w_cnt_nxt   = r_cnt + {3'd0, w_push} - {3'd0, w_pop};
   // The popped entry stays counted while its write is on the port.
   assign w_level_nxt = w_cnt_nxt + {3'd0, w_pop};
   assign w_ready_nxt = (w_state_nxt == ST_RUN) && (w_level_nxt < LVL_FULL);

   // Next-state logic for IDLE / RUN / FLUSH.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (ENABLE_I) w_state_nxt = ST_RUN;
            else          w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (ENABLE_I)                w_state_nxt = ST_RUN;
            else if (w_cnt_nxt == 4'd0)  w_state_nxt = ST_IDLE;
            else                         w_state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (ENABLE_I)                w_state_nxt = ST_RUN;
            else if (w_cnt_nxt == 4'd0)  w_state_nxt = ST_IDLE;
            else                         w_state_nxt = ST_FLUSH;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FIFO storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge CLK_25_I) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= WR_ADDR_I;
         r_fifo_data[r_wr_ptr] <= WR_DATA_I;
      end
   end

   // FSM, FIFO bookkeeping and status outputs.
   always_ff @(posedge CLK_25_I) begin
      if (RST_I) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_level    <= 4'd0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_wr_ready <= 1'b0;
         r_drop     <= 16'd0;
         r_addr_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_level    <= w_level_nxt;
         r_wr_ready <= w_ready_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
         if (w_bad_addr) r_addr_err <= 1'b1;
      end
   end

   // BRAM port drive and read-return pipeline.
   always_ff @(posedge CLK_25_I) begin
      if (RST_I) begin
         r_bram_en    <= 1'b0;
         r_bram_we    <= 1'b0;
         r_bram_addr  <= '0;
         r_bram_wdata <= '0;
         r_rd_p1      <= 1'b0;
         r_rd_p2      <= 1'b0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_bram_en <= w_rd_slot || w_pop;
         r_bram_we <= w_pop;
         if (w_rd_slot) begin
            r_bram_addr <= RD_ADDR_I;
         end else if (w_pop) begin
            r_bram_addr  <= r_fifo_addr[r_rd_ptr];
            r_bram_wdata <= r_fifo_data[r_rd_ptr];
         end
         r_rd_p1    <= w_rd_slot;
         r_rd_p2    <= r_rd_p1;
         r_rd_valid <= r_rd_p2;
         if (r_rd_p2) r_rd_data <= BRAM_RDATA_I;
      end
   end

   assign WR_READY_O   = r_wr_ready;
   assign RD_DATA_O    = r_rd_data;
   assign RD_VALID_O   = r_rd_valid;
   assign BRAM_EN_O    = r_bram_en;
   assign BRAM_WE_O    = r_bram_we;
   assign BRAM_ADDR_O  = r_bram_addr;
   assign BRAM_WDATA_O = r_bram_wdata;
   assign FIFO_LEVEL_O = r_level;
   assign DROP_CNT_O   = r_drop;
   assign ADDR_ERR_O   = r_addr_err;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_port_arbiter
// Scoreboard bench: a transaction-level model of the arbiter (mode, write
// queue, reference memory) predicts every BRAM access, every read return and
// the status outputs; a negedge monitor compares what the DUT presents.
// -----------------------------------------------------------------------------
module tb_fb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        wv = 1'b0;
   logic [14:0] wa = 15'd0;
   logic [11:0] wd = 12'd0;
   logic        rd = 1'b0;
   logic [14:0] ra = 15'd0;
   logic        wr_ready, rd_valid, bram_en, bram_we, addr_err;
   logic [11:0] rd_data, bram_wdata;
   logic [11:0] bram_rdata = 12'd0;
   logic [14:0] bram_addr;
   logic [3:0]  fifo_level;
   logic [15:0] drop_cnt;

   fb_port_arbiter dut (
      .CLK_25_I(clk), .RST_I(rst), .ENABLE_I(en),
      .WR_VALID_I(wv), .WR_ADDR_I(wa), .WR_DATA_I(wd), .WR_READY_O(wr_ready),
      .RD_EN_I(rd), .RD_ADDR_I(ra), .RD_DATA_O(rd_data), .RD_VALID_O(rd_valid),
      .BRAM_EN_O(bram_en), .BRAM_WE_O(bram_we), .BRAM_ADDR_O(bram_addr),
      .BRAM_WDATA_O(bram_wdata), .BRAM_RDATA_I(bram_rdata),
      .FIFO_LEVEL_O(fifo_level), .DROP_CNT_O(drop_cnt), .ADDR_ERR_O(addr_err)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM primitive model, 1-cycle read latency
   logic [11:0] bram_mem [0:32767];
   logic [11:0] ref_mem  [0:32767];
   always @(posedge clk) begin
      if (bram_en === 1'b1) begin
         if (bram_we === 1'b1) bram_mem[bram_addr] <= bram_wdata;
         else                  bram_rdata <= bram_mem[bram_addr];
      end
   end

   typedef struct { int stamp; bit we; logic [14:0] addr; logic [11:0] data; } op_t;
   typedef struct { int stamp; logic [11:0] data; } rd_t;
   typedef struct { int stamp; logic [3:0] level; bit ready; logic [15:0] drop;
                    bit err; logic [14:0] addr; logic [11:0] wdata; bit full; } st_t;
   typedef enum {M_IDLE, M_RUN, M_FLUSH} mode_t;

   op_t         opq[$];
   rd_t         rdq[$];
   st_t         stq[$];
   logic [26:0] wq[$];

   mode_t       m_mode = M_IDLE;
   bit          m_known = 1'b0;
   bit          m_rstchk = 1'b0;
   logic [3:0]  m_level = 4'd0;
   bit          m_ready = 1'b0;
   logic [15:0] m_drop = 16'd0;
   bit          m_err = 1'b0;
   logic [14:0] m_addr = 15'd0;
   logic [11:0] m_wdata = 12'd0;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: advance one cycle using the inputs currently driven.
   task automatic step_model();
      st_t s;
      op_t o;
      rd_t r;
      logic [26:0] e;
      bit active, wr_issue;
      int pre;
      s.stamp = cyc; s.level = m_level; s.ready = m_ready; s.drop = m_drop;
      s.err = m_err; s.addr = m_addr; s.wdata = m_wdata; s.full = m_rstchk;
      if (m_known) stq.push_back(s);
      m_rstchk = 1'b0;
      if (rst) begin
         m_known = 1'b1; m_rstchk = 1'b1; m_mode = M_IDLE; wq.delete();
         m_level = 4'd0; m_ready = 1'b0; m_drop = 16'd0; m_err = 1'b0;
         m_addr = 15'd0; m_wdata = 12'd0;
         while (opq.size() > 0 && opq[$].stamp > cyc) void'(opq.pop_back());
         while (rdq.size() > 0 && rdq[$].stamp > cyc) void'(rdq.pop_back());
         return;
      end
      if (!m_known) return;
      active = (m_mode != M_IDLE);
      pre = wq.size();
      wr_issue = 1'b0;
      if (active && rd) begin
         o.stamp = cyc + 1; o.we = 1'b0; o.addr = ra; o.data = m_wdata;
         opq.push_back(o);
         r.stamp = cyc + 3; r.data = ref_mem[ra];
         rdq.push_back(r);
         m_addr = ra;
      end else if (active && pre > 0) begin
         e = wq.pop_front();
         o.stamp = cyc + 1; o.we = 1'b1; o.addr = e[26:12]; o.data = e[11:0];
         opq.push_back(o);
         ref_mem[o.addr] = o.data;
         m_addr = o.addr; m_wdata = o.data;
         wr_issue = 1'b1;
      end
      if (wv) begin
         if (!m_ready) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
         end else if (wa < 15'd30720) begin
            wq.push_back({wa, wd});
         end else begin
            m_err = 1'b1;
         end
      end
      case (m_mode)
         M_IDLE:  if (en) m_mode = M_RUN;
         M_RUN:   if (!en) m_mode = (wq.size() == 0) ? M_IDLE : M_FLUSH;
         M_FLUSH: if (en) m_mode = M_RUN; else if (wq.size() == 0) m_mode = M_IDLE;
         default: m_mode = M_IDLE;
      endcase
      m_level = 4'(wq.size() + int'(wr_issue));
      m_ready = (m_mode == M_RUN) && (m_level < 4'd8);
   endtask

   task automatic drive(input bit i_en, input bit i_rd, input logic [14:0] i_ra,
                        input bit i_wv, input logic [14:0] i_wa, input logic [11:0] i_wd,
                        input bit i_rst);
      en = i_en; rd = i_rd; ra = i_ra; wv = i_wv; wa = i_wa; wd = i_wd; rst = i_rst;
      step_model();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      st_t s;
      op_t o;
      rd_t r;
      bit exp_en, exp_rv;
      if (mon_on) begin
         if (stq.size() > 0 && stq[0].stamp == cyc) begin
            s = stq.pop_front();
            chk("fifo_level", {28'd0, fifo_level}, {28'd0, s.level});
            chk("wr_ready", {31'd0, wr_ready}, {31'd0, s.ready});
            chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, s.drop});
            chk("addr_err", {31'd0, addr_err}, {31'd0, s.err});
            chk("bram_addr", {17'd0, bram_addr}, {17'd0, s.addr});
            chk("bram_wdata", {20'd0, bram_wdata}, {20'd0, s.wdata});
            if (s.full) begin
               chk("rst_bram_we", {31'd0, bram_we}, 32'd0);
               chk("rst_rd_data", {20'd0, rd_data}, 32'd0);
            end
         end
         exp_en = (opq.size() > 0 && opq[0].stamp == cyc);
         chk("bram_en", {31'd0, bram_en}, {31'd0, exp_en});
         if (opq.size() > 0 && opq[0].stamp <= cyc) begin
            o = opq.pop_front();
            if (bram_en === 1'b1) begin
               chk("bram_we", {31'd0, bram_we}, {31'd0, o.we});
               chk("op_addr", {17'd0, bram_addr}, {17'd0, o.addr});
               if (o.we) chk("op_wdata", {20'd0, bram_wdata}, {20'd0, o.data});
            end
         end
         exp_rv = (rdq.size() > 0 && rdq[0].stamp == cyc);
         chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
         if (rdq.size() > 0 && rdq[0].stamp <= cyc) begin
            r = rdq.pop_front();
            if (rd_valid === 1'b1) chk("rd_data", {20'd0, rd_data}, {20'd0, r.data});
         end
      end
   end

   initial begin
      logic [11:0] v;
      for (int i = 0; i < 32768; i++) begin
         v = 12'($urandom);
         bram_mem[i] = v;
         ref_mem[i]  = v;
      end
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b1);
      mon_on = 1'b1;
      drive(1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b1);
      drive(1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);

      // 640 back-to-back display reads
      drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);
      for (int i = 0; i < 640; i++) drive(1'b1, 1'b1, 15'(i), 1'b0, 15'd0, 12'd0, 1'b0);
      for (int i = 0; i < 5; i++)   drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);

      // single write, then read it back
      drive(1'b1, 1'b0, 15'd0, 1'b1, 15'd100, 12'hABC, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);
      drive(1'b1, 1'b1, 15'd100, 1'b0, 15'd0, 12'd0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);

      // 10 writes offered under continuous reads, then drain
      for (int i = 0; i < 10; i++)
         drive(1'b1, 1'b1, 15'(i), 1'b1, 15'(200 + i), 12'(16'h100 + i), 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 15'd5, 1'b0, 15'd0, 12'd0, 1'b0);
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);

      // out-of-range write
      drive(1'b1, 1'b0, 15'd0, 1'b1, 15'd30720, 12'h555, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);

      // 5 writes under reads, then disable -> flush -> idle, reads ignored
      for (int i = 0; i < 5; i++)
         drive(1'b1, 1'b1, 15'(300 + i), 1'b1, 15'(300 + i), 12'(16'h700 + i), 1'b0);
      drive(1'b0, 1'b1, 15'd1, 1'b1, 15'd50, 12'h123, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 15'd0, 1'b1, 15'd51, 12'h321, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 15'(300 + i), 1'b0, 15'd0, 12'd0, 1'b0);

      // reset with 4 queued writes and reads in flight
      drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b1, 1'b1, 15'(i), 1'b1, 15'(400 + i), 12'(16'h900 + i), 1'b0);
      drive(1'b1, 1'b1, 15'd7, 1'b0, 15'd0, 12'd0, 1'b1);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 15'(400 + i), 1'b0, 15'd0, 12'd0, 1'b0);

      // randomized traffic over a small address window
      for (int i = 0; i < 3000; i++) begin
         logic [14:0] a_w;
         a_w = ($urandom_range(0, 99) < 3) ? 15'(30720 + $urandom_range(0, 2047))
                                          : 15'($urandom_range(0, 63));
         drive($urandom_range(0, 99) < 93, $urandom_range(0, 99) < 50,
               15'($urandom_range(0, 63)), $urandom_range(0, 1) == 1, a_w,
               12'($urandom), $urandom_range(0, 999) < 4);
      end

      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 12'd0, 1'b0);
      chk("ops_outstanding", opq.size(), 32'd0);
      chk("reads_outstanding", rdq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
